bank_conflict_scheduler: RTL and testbench
==========================================

# bank_conflict_scheduler

Sequences the bank-input scatter network. It accepts one packed batch of 2·P lane requests, each an address plus a bank index. It splits the batch into conflict-free beats, so that no two lanes in a beat target the same bank, and presents each beat to the scatter network with a valid/ready handshake. It sits between the address-generation stage and the scatter network, so that the network never sees two addresses routed to the same bank in one cycle.

## Interface
- N_LANES, default 2*`P: lane count, which is also the number of requesters per batch.
- ADDR_WIDTH, default `ADDR_WIDTH: width of each lane address.
- MAP, default `MAP: width of each lane bank index.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- in_valid  in  1  a batch is offered.
- in_ready  out  1  scheduler can accept a batch.
- in_ba_bus  in  N_LANES*ADDR_WIDTH  packed lane addresses; lane i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- in_bi_bus  in  N_LANES*MAP  packed lane bank indices, same packing rule.
- in_mask  in  N_LANES  lane i carries a request when bit i is 1.
- out_valid  out  1  beat is presented.
- out_ready  in  1  downstream consumes the beat.
- out_ba_bus  out  N_LANES*ADDR_WIDTH  addresses of granted lanes; non-granted lanes are 0.
- out_bi_bus  out  N_LANES*MAP  bank indices of granted lanes; non-granted lanes are 0.
- out_mask  out  N_LANES  lanes granted in this beat.
- out_last  out  1  this beat completes the batch.
- beat_cnt  out  $clog2(N_LANES)+1  index of the current beat within the batch, starting at 0.

## Operation
- **States:** IDLE and ISSUE.
- **IDLE:**
  - in_ready = 1.
  - On in_valid && in_ready, register in_ba_bus, in_bi_bus and in_mask into hold registers.
  - pending ← in_mask.
  - If in_mask != 0, go to ISSUE; if in_mask == 0, the batch is consumed, no beat is emitted, and the state stays IDLE.
- **ISSUE:**
  - in_ready = 0; out_valid = 1.
  - Grant rule: scan pending lanes from lane 0 upward. Lane i is granted if it is pending and no lower-indexed pending lane has an equal bank index. Exactly one lane per distinct bank index is granted, always the lowest-indexed one.
  - out_mask = grant. out_ba_bus and out_bi_bus carry the held values on granted lanes and 0 elsewhere.
  - out_last = 1 when grant == pending.
  - On out_valid && out_ready: pending ← pending & ~grant, and beat_cnt increments. If out_last is set, go to IDLE and clear beat_cnt.
- **Stability:** grant is a pure function of the pending and hold registers. All out_* signals therefore stay stable while out_valid && !out_ready.
- **Beat count:** a batch produces as many beats as the maximum number of pending lanes sharing one bank index. The bound is N_LANES beats, so beat_cnt never overflows its width.
- **Bank index range:** bank indices are compared over the full MAP bits. Values ≥ N_LANES are scheduled normally, and the downstream network defines what they mean.

## Timing
- **Reset** (rst_n low at a clock edge):
  - state = IDLE; pending = 0; hold registers = 0; beat_cnt = 0.
  - out_valid = 0; out_mask = 0; out_last = 0; out_ba_bus = 0; out_bi_bus = 0.
  - in_ready = 1 from the first clock after reset.
- **Reset mid-batch:** the remaining pending lanes are discarded, with no further beats.
- **Latency:** the batch is accepted at edge k; the first beat is valid during cycle k+1. One beat is issued per cycle while out_ready = 1.
- **Back-to-back batches:** a new batch can be accepted no earlier than the cycle after the out_last handshake. Throughput is therefore one batch per (beats + 1) cycles.
- **Input while busy:** in_valid during ISSUE is ignored, because in_ready = 0. The upstream source must hold the batch until it is accepted.
- **Registered outputs:** in_ready, out_valid and beat_cnt are registered-state functions, with no combinational path from in_valid or out_ready. out_mask, out_last and the output buses are combinational from registers only.

## Structure
- Shared package/header:
  - the lane-unpacking helper constants;
  - the FSM state encoding (IDLE = 0, ISSUE = 1);
  - the beat_cnt width expression.
  - These join the existing parameter definitions (`P, `ADDR_WIDTH, `MAP).
- Sub-module `bank_grant_select` (combinational): inputs are the pending mask and the unpacked bank indices; outputs are the grant mask and last. It implements the lowest-index-per-bank rule with an N_LANES×N_LANES equality/priority matrix. The top level holds the FSM, the hold registers, the handshakes and the output masking.

## Test plan
Scenarios 1–5 use P = 2, so N_LANES = 4, MAP = 2.
1. **Distinct banks:** BI = {3,2,1,0} on lanes 3..0, mask 1111 → one beat, out_mask 1111, out_last = 1, beat_cnt 0. in_ready returns to 1 two cycles after acceptance.
2. **Full conflict:** all BI = 2, mask 1111 → four beats with out_mask 0001, 0010, 0100, 1000. beat_cnt runs 0..3. out_last = 1 only on the fourth beat.
3. **Pairwise conflict:** lanes 0..3 have BI = 0,0,1,1 → beats 0101 then 1010. Granted addresses appear on their own lanes; other lanes are 0.
4. **Backpressure and ignored input:** during scenario 2, hold out_ready = 0 for 3 cycles on beat 1 → out_mask stays 0010 and the buses are unchanged. Keep in_valid = 1 throughout → no second batch is accepted until after out_last.
5. **Empty batch and sparse mask:**
   - Batch with mask 0000 is accepted and out_valid never rises.
   - Batch with mask 1001, both lanes BI = 1, gives beats 0001 then 1000.
6. **Reset mid-batch:** pulse rst_n low during beat 2 of scenario 2 → the next cycle shows out_valid = 0, in_ready = 1, beat_cnt = 0, and no residual beats.

Source files
------------

// File: rtl/bank_conflict_scheduler_pkg.sv
// Shared definitions for the bank conflict scheduler: default geometry,
// FSM state encoding and the beat counter width rule.
package bank_conflict_scheduler_pkg;

  localparam int unsigned DEF_P          = 2;
  localparam int unsigned DEF_ADDR_WIDTH = 8;
  localparam int unsigned DEF_MAP        = 2;
  localparam int unsigned DEF_N_LANES    = 2 * DEF_P;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_e;

  // A batch needs at most N_LANES beats, so indices 0..N_LANES must fit.
  function automatic int unsigned beat_cnt_w(input int unsigned n_lanes);
    return $clog2(n_lanes) + 1;
  endfunction

endpackage

// File: rtl/bank_conflict_scheduler_if.sv
// Batch-in / beat-out handshake bundle for the bank conflict scheduler.
interface bank_conflict_scheduler_if
  import bank_conflict_scheduler_pkg::*;
#(
  parameter int unsigned N_LANES    = DEF_N_LANES,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned MAP        = DEF_MAP
);
  localparam int unsigned CW = beat_cnt_w(N_LANES);

  logic                          in_valid;
  logic                          in_ready;
  logic [N_LANES*ADDR_WIDTH-1:0] in_ba_bus;
  logic [N_LANES*MAP-1:0]        in_bi_bus;
  logic [N_LANES-1:0]            in_mask;
  logic                          out_valid;
  logic                          out_ready;
  logic [N_LANES*ADDR_WIDTH-1:0] out_ba_bus;
  logic [N_LANES*MAP-1:0]        out_bi_bus;
  logic [N_LANES-1:0]            out_mask;
  logic                          out_last;
  logic [CW-1:0]                 beat_cnt;

  modport slave (
    input  in_valid, in_ba_bus, in_bi_bus, in_mask, out_ready,
    output in_ready, out_valid, out_ba_bus, out_bi_bus, out_mask, out_last, beat_cnt
  );

  modport master (
    output in_valid, in_ba_bus, in_bi_bus, in_mask, out_ready,
    input  in_ready, out_valid, out_ba_bus, out_bi_bus, out_mask, out_last, beat_cnt
  );

endinterface

// File: rtl/bank_grant_select.sv
// Grants the lowest-indexed pending lane of every distinct bank index.
module bank_grant_select #(
  parameter int unsigned N_LANES = 4,
  parameter int unsigned MAP     = 2
) (
  input  logic [N_LANES-1:0]          pending_i,
  input  logic [N_LANES-1:0][MAP-1:0] bi_i,
  output logic [N_LANES-1:0]          grant_o,
  output logic                        last_o
);

  // blocked[i][j]: lower pending lane j already claims lane i's bank.
  logic [N_LANES-1:0][N_LANES-1:0] blocked;

  always_comb begin
    blocked = '0;
    grant_o = '0;
    for (int unsigned i = 0; i < N_LANES; i++) begin
      for (int unsigned j = 0; j < i; j++) begin
        blocked[i][j] = pending_i[j] && (bi_i[j] == bi_i[i]);
      end
      grant_o[i] = pending_i[i] && !(|blocked[i]);
    end
    last_o = (grant_o == pending_i);
  end

endmodule

// File: rtl/bank_conflict_scheduler.sv
// Holds one batch of lane requests and issues it as conflict-free beats.
module bank_conflict_scheduler
  import bank_conflict_scheduler_pkg::*;
#(
  parameter int unsigned N_LANES    = DEF_N_LANES,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned MAP        = DEF_MAP
) (
  input logic                      clk,
  input logic                      rst_n,
  bank_conflict_scheduler_if.slave bus
);

  localparam int unsigned CW = beat_cnt_w(N_LANES);

  state_e                             state_q, state_d;
  logic [N_LANES-1:0]                 pending_q, pending_d;
  logic [N_LANES-1:0][ADDR_WIDTH-1:0] ba_q, ba_d, ba_out;
  logic [N_LANES-1:0][MAP-1:0]        bi_q, bi_d, bi_out;
  logic [CW-1:0]                      cnt_q, cnt_d;
  logic [N_LANES-1:0]                 grant;
  logic                               last;
  logic                               issuing;

  bank_grant_select #(
    .N_LANES (N_LANES),
    .MAP     (MAP)
  ) u_grant (
    .pending_i (pending_q),
    .bi_i      (bi_q),
    .grant_o   (grant),
    .last_o    (last)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      ba_q      <= '0;
      bi_q      <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      ba_q      <= ba_d;
      bi_q      <= bi_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    ba_d      = ba_q;
    bi_d      = bi_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          ba_d      = bus.in_ba_bus;
          bi_d      = bus.in_bi_bus;
          pending_d = bus.in_mask;
          cnt_d     = '0;
          // An empty batch is consumed without producing a beat.
          if (|bus.in_mask) state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.out_ready) begin
          pending_d = pending_q & ~grant;
          if (last) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = CW'(cnt_q + 1'b1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    issuing = (state_q == ISSUE);
    ba_out  = '0;
    bi_out  = '0;
    for (int unsigned i = 0; i < N_LANES; i++) begin
      if (issuing && grant[i]) begin
        ba_out[i] = ba_q[i];
        bi_out[i] = bi_q[i];
      end
    end
    bus.in_ready   = !issuing;
    bus.out_valid  = issuing;
    bus.out_mask   = issuing ? grant : '0;
    bus.out_last   = issuing && last;
    bus.out_ba_bus = ba_out;
    bus.out_bi_bus = bi_out;
    bus.beat_cnt   = cnt_q;
  end

endmodule

// File: tb/tb_bank_conflict_scheduler.sv
// Directed checks of batch splitting, backpressure, sparse/empty batches and reset.
module tb_bank_conflict_scheduler;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  bank_conflict_scheduler_if #(.N_LANES(4), .ADDR_WIDTH(8), .MAP(2)) bus ();

  bank_conflict_scheduler #(
    .N_LANES    (4),
    .ADDR_WIDTH (8),
    .MAP        (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {in_ready, out_valid, out_last, out_mask[3:0], beat_cnt[2:0]}
  function automatic logic [9:0] st();
    return {bus.in_ready, bus.out_valid, bus.out_last, bus.out_mask, bus.beat_cnt};
  endfunction

  localparam logic [9:0] ST_IDLE = {1'b1, 1'b0, 1'b0, 4'b0000, 3'd0};

  // Called just after a falling edge; returns after the accepting rising edge.
  task automatic offer(input logic [31:0] ba, input logic [7:0] bi, input logic [3:0] m);
    bus.in_valid  = 1'b1;
    bus.in_ba_bus = ba;
    bus.in_bi_bus = bi;
    bus.in_mask   = m;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (st() !== ST_IDLE) begin n_err++; $display("FAIL reset_status got %b exp %b", st(), ST_IDLE); end
    n_cmp++; if (bus.out_ba_bus !== 32'h0) begin n_err++; $display("FAIL reset_ba got %h exp %h", bus.out_ba_bus, 32'h0); end
    n_cmp++; if (bus.out_bi_bus !== 8'h0) begin n_err++; $display("FAIL reset_bi got %h exp %h", bus.out_bi_bus, 8'h0); end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (st() !== ST_IDLE) begin n_err++; $display("FAIL post_reset_status got %b exp %b", st(), ST_IDLE); end
  endtask

  task automatic test_distinct();
    offer(32'hD3C2B1A0, 8'hE4, 4'b1111);
    bus.in_valid = 1'b0;
    n_cmp++; if (st() !== {1'b0, 1'b1, 1'b1, 4'b1111, 3'd0}) begin n_err++; $display("FAIL distinct_status got %b exp %b", st(), {1'b0, 1'b1, 1'b1, 4'b1111, 3'd0}); end
    n_cmp++; if (bus.out_ba_bus !== 32'hD3C2B1A0) begin n_err++; $display("FAIL distinct_ba got %h exp %h", bus.out_ba_bus, 32'hD3C2B1A0); end
    n_cmp++; if (bus.out_bi_bus !== 8'hE4) begin n_err++; $display("FAIL distinct_bi got %h exp %h", bus.out_bi_bus, 8'hE4); end
    @(negedge clk);
    n_cmp++; if (st() !== ST_IDLE) begin n_err++; $display("FAIL distinct_ready_back got %b exp %b", st(), ST_IDLE); end
  endtask

  // Full conflict with a stall on beat 1 and a different batch held on the input.
  task automatic test_backpressure();
    offer(32'h44332211, 8'hAA, 4'b1111);
    bus.in_ba_bus = 32'hFFFFFFFF;
    bus.in_bi_bus = 8'hE4;
    bus.in_mask   = 4'b1111;
    n_cmp++; if (st() !== {1'b0, 1'b1, 1'b0, 4'b0001, 3'd0}) begin n_err++; $display("FAIL conflict_b0_status got %b exp %b", st(), {1'b0, 1'b1, 1'b0, 4'b0001, 3'd0}); end
    n_cmp++; if (bus.out_ba_bus !== 32'h00000011) begin n_err++; $display("FAIL conflict_b0_ba got %h exp %h", bus.out_ba_bus, 32'h00000011); end
    n_cmp++; if (bus.out_bi_bus !== 8'h02) begin n_err++; $display("FAIL conflict_b0_bi got %h exp %h", bus.out_bi_bus, 8'h02); end
    @(negedge clk);
    n_cmp++; if (st() !== {1'b0, 1'b1, 1'b0, 4'b0010, 3'd1}) begin n_err++; $display("FAIL conflict_b1_status got %b exp %b", st(), {1'b0, 1'b1, 1'b0, 4'b0010, 3'd1}); end
    n_cmp++; if (bus.out_bi_bus !== 8'h08) begin n_err++; $display("FAIL conflict_b1_bi got %h exp %h", bus.out_bi_bus, 8'h08); end
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++; if (st() !== {1'b0, 1'b1, 1'b0, 4'b0010, 3'd1}) begin n_err++; $display("FAIL stall%0d_status got %b exp %b", i, st(), {1'b0, 1'b1, 1'b0, 4'b0010, 3'd1}); end
      n_cmp++; if (bus.out_ba_bus !== 32'h00002200) begin n_err++; $display("FAIL stall%0d_ba got %h exp %h", i, bus.out_ba_bus, 32'h00002200); end
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (st() !== {1'b0, 1'b1, 1'b0, 4'b0100, 3'd2}) begin n_err++; $display("FAIL conflict_b2_status got %b exp %b", st(), {1'b0, 1'b1, 1'b0, 4'b0100, 3'd2}); end
    n_cmp++; if (bus.out_ba_bus !== 32'h00330000) begin n_err++; $display("FAIL conflict_b2_ba got %h exp %h", bus.out_ba_bus, 32'h00330000); end
    @(negedge clk);
    n_cmp++; if (st() !== {1'b0, 1'b1, 1'b1, 4'b1000, 3'd3}) begin n_err++; $display("FAIL conflict_b3_status got %b exp %b", st(), {1'b0, 1'b1, 1'b1, 4'b1000, 3'd3}); end
    n_cmp++; if (bus.out_ba_bus !== 32'h44000000) begin n_err++; $display("FAIL conflict_b3_ba got %h exp %h", bus.out_ba_bus, 32'h44000000); end
    n_cmp++; if (bus.out_bi_bus !== 8'h80) begin n_err++; $display("FAIL conflict_b3_bi got %h exp %h", bus.out_bi_bus, 8'h80); end
    @(negedge clk);
    n_cmp++; if (st() !== ST_IDLE) begin n_err++; $display("FAIL conflict_idle got %b exp %b", st(), ST_IDLE); end
    @(negedge clk);
    bus.in_valid = 1'b0;
    n_cmp++; if (st() !== {1'b0, 1'b1, 1'b1, 4'b1111, 3'd0}) begin n_err++; $display("FAIL held_batch_status got %b exp %b", st(), {1'b0, 1'b1, 1'b1, 4'b1111, 3'd0}); end
    n_cmp++; if (bus.out_ba_bus !== 32'hFFFFFFFF) begin n_err++; $display("FAIL held_batch_ba got %h exp %h", bus.out_ba_bus, 32'hFFFFFFFF); end
    @(negedge clk);
    n_cmp++; if (st() !== ST_IDLE) begin n_err++; $display("FAIL held_batch_idle got %b exp %b", st(), ST_IDLE); end
  endtask

  task automatic test_pairwise();
    offer(32'h87654321, 8'h50, 4'b1111);
    bus.in_valid = 1'b0;
    n_cmp++; if (st() !== {1'b0, 1'b1, 1'b0, 4'b0101, 3'd0}) begin n_err++; $display("FAIL pair_b0_status got %b exp %b", st(), {1'b0, 1'b1, 1'b0, 4'b0101, 3'd0}); end
    n_cmp++; if (bus.out_ba_bus !== 32'h00650021) begin n_err++; $display("FAIL pair_b0_ba got %h exp %h", bus.out_ba_bus, 32'h00650021); end
    n_cmp++; if (bus.out_bi_bus !== 8'h10) begin n_err++; $display("FAIL pair_b0_bi got %h exp %h", bus.out_bi_bus, 8'h10); end
    @(negedge clk);
    n_cmp++; if (st() !== {1'b0, 1'b1, 1'b1, 4'b1010, 3'd1}) begin n_err++; $display("FAIL pair_b1_status got %b exp %b", st(), {1'b0, 1'b1, 1'b1, 4'b1010, 3'd1}); end
    n_cmp++; if (bus.out_ba_bus !== 32'h87004300) begin n_err++; $display("FAIL pair_b1_ba got %h exp %h", bus.out_ba_bus, 32'h87004300); end
    n_cmp++; if (bus.out_bi_bus !== 8'h40) begin n_err++; $display("FAIL pair_b1_bi got %h exp %h", bus.out_bi_bus, 8'h40); end
    @(negedge clk);
    n_cmp++; if (st() !== ST_IDLE) begin n_err++; $display("FAIL pair_idle got %b exp %b", st(), ST_IDLE); end
  endtask

  task automatic test_sparse();
    offer(32'h12345678, 8'hAB, 4'b0000);
    bus.in_valid = 1'b0;
    n_cmp++; if (st() !== ST_IDLE) begin n_err++; $display("FAIL empty_status got %b exp %b", st(), ST_IDLE); end
    @(negedge clk);
    n_cmp++; if (st() !== ST_IDLE) begin n_err++; $display("FAIL empty_status2 got %b exp %b", st(), ST_IDLE); end
    offer(32'hCAFEBABE, 8'h55, 4'b1001);
    bus.in_valid = 1'b0;
    n_cmp++; if (st() !== {1'b0, 1'b1, 1'b0, 4'b0001, 3'd0}) begin n_err++; $display("FAIL sparse_b0_status got %b exp %b", st(), {1'b0, 1'b1, 1'b0, 4'b0001, 3'd0}); end
    n_cmp++; if (bus.out_ba_bus !== 32'h000000BE) begin n_err++; $display("FAIL sparse_b0_ba got %h exp %h", bus.out_ba_bus, 32'h000000BE); end
    n_cmp++; if (bus.out_bi_bus !== 8'h01) begin n_err++; $display("FAIL sparse_b0_bi got %h exp %h", bus.out_bi_bus, 8'h01); end
    @(negedge clk);
    n_cmp++; if (st() !== {1'b0, 1'b1, 1'b1, 4'b1000, 3'd1}) begin n_err++; $display("FAIL sparse_b1_status got %b exp %b", st(), {1'b0, 1'b1, 1'b1, 4'b1000, 3'd1}); end
    n_cmp++; if (bus.out_ba_bus !== 32'hCA000000) begin n_err++; $display("FAIL sparse_b1_ba got %h exp %h", bus.out_ba_bus, 32'hCA000000); end
    n_cmp++; if (bus.out_bi_bus !== 8'h40) begin n_err++; $display("FAIL sparse_b1_bi got %h exp %h", bus.out_bi_bus, 8'h40); end
    @(negedge clk);
    n_cmp++; if (st() !== ST_IDLE) begin n_err++; $display("FAIL sparse_idle got %b exp %b", st(), ST_IDLE); end
  endtask

  task automatic test_reset_mid_batch();
    offer(32'h44332211, 8'hAA, 4'b1111);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (st() !== {1'b0, 1'b1, 1'b0, 4'b0100, 3'd2}) begin n_err++; $display("FAIL midrst_b2_status got %b exp %b", st(), {1'b0, 1'b1, 1'b0, 4'b0100, 3'd2}); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_cmp++; if (st() !== ST_IDLE) begin n_err++; $display("FAIL midrst_status got %b exp %b", st(), ST_IDLE); end
    n_cmp++; if (bus.out_ba_bus !== 32'h0) begin n_err++; $display("FAIL midrst_ba got %h exp %h", bus.out_ba_bus, 32'h0); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++; if (st() !== ST_IDLE) begin n_err++; $display("FAIL midrst_residual%0d got %b exp %b", i, st(), ST_IDLE); end
    end
  endtask

  initial begin
    n_cmp         = 0;
    n_err         = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_ba_bus = '0;
    bus.in_bi_bus = '0;
    bus.in_mask   = '0;
    bus.out_ready = 1'b1;
    test_reset();
    test_distinct();
    test_backpressure();
    test_pairwise();
    test_sparse();
    test_reset_mid_batch();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
